// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: FSM state encoding and default widths used by
// both the stream master and the matching slave.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_FIFO_DEPTH = 4;
    localparam int AXIS_LEN_WIDTH  = 8;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } axis_state_e;

endpackage

// File: rtl/axis_fifo.sv
// Power-of-two beat FIFO with registered occupancy count; read data is the
// current head. Writes when full and reads when empty are ignored.
module axis_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic                     rd_en_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_ok_s, rd_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == CW'(0));
    assign wr_ok_s   = wr_en_i & ~full_o;
    assign rd_ok_s   = rd_en_i & ~empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next-state; pointers wrap through their natural width
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({wr_ok_s, rd_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (wr_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/axis_m.sv
// AXI-Stream master: buffers user beats in a FIFO and emits them in packets of
// pkt_len beats through a fully registered output stage.
module axis_m
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int FIFO_DEPTH = AXIS_FIFO_DEPTH,
    parameter int LEN_WIDTH  = AXIS_LEN_WIDTH
) (
    input  logic                  aclk,
    input  logic                  areset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  send,
    output logic                  full,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    output logic                  tvalid,
    input  logic                  tready,
    output logic                  tlast,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  finish
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    axis_state_e           state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  finish_q, finish_d;

    logic                  handshake_s, load_s, close_s;
    logic                  fifo_empty_s, fifo_full_s;
    logic [DATA_WIDTH-1:0] fifo_head_s;
    logic [CW-1:0]         fifo_count_s;
    logic [LEN_WIDTH-1:0]  len_eff_s, cnt_inc_s;

    assign handshake_s = tvalid_q & tready;
    // The output stage refills whenever it is empty or being drained this edge
    assign load_s      = ~fifo_empty_s & (~tvalid_q | handshake_s);
    assign full        = (fifo_count_s == CW'(FIFO_DEPTH));

    axis_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (aclk),
        .rst_ni     (areset_n),
        .wr_en_i    (send & ~fifo_full_s),
        .wr_data_i  (data),
        .rd_en_i    (load_s),
        .rd_data_o  (fifo_head_s),
        .full_o     (fifo_full_s),
        .empty_o    (fifo_empty_s),
        .count_o    (fifo_count_s)
    );

    // Packet FSM: decides on each load whether the loaded beat closes the packet
    always_comb begin
        len_eff_s  = (pkt_len == LEN_WIDTH'(0)) ? LEN_WIDTH'(1) : pkt_len;
        cnt_inc_s  = beat_cnt_q + LEN_WIDTH'(1);
        state_d    = state_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        close_s    = 1'b0;
        if (load_s) begin
            case (state_q)
                IDLE: begin
                    len_d      = len_eff_s;
                    beat_cnt_d = LEN_WIDTH'(1);
                    if (len_eff_s == LEN_WIDTH'(1)) begin
                        close_s = 1'b1;
                        state_d = IDLE;
                    end else begin
                        close_s = 1'b0;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    beat_cnt_d = cnt_inc_s;
                    if (cnt_inc_s == len_q) begin
                        close_s = 1'b1;
                        state_d = IDLE;
                    end else begin
                        close_s = 1'b0;
                        state_d = ACTIVE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    close_s = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output stage next-state: load, drop valid on drain, else hold
    always_comb begin
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tdata_d  = tdata_q;
        finish_d = handshake_s & tlast_q;
        if (load_s) begin
            tvalid_d = 1'b1;
            tlast_d  = close_s;
            tdata_d  = fifo_head_s;
        end else if (handshake_s) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tdata_d  = tdata_q;
        end else begin
            tvalid_d = tvalid_q;
            tlast_d  = tlast_q;
            tdata_d  = tdata_q;
        end
    end

    // FSM and output registers
    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q    <= IDLE;
            len_q      <= LEN_WIDTH'(0);
            beat_cnt_q <= LEN_WIDTH'(0);
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= DATA_WIDTH'(0);
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            tdata_q    <= tdata_d;
            finish_q   <= finish_d;
        end
    end

    assign tvalid = tvalid_q;
    assign tlast  = tlast_q;
    assign tdata  = tdata_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_axis_m.sv
// Directed self-checking bench for axis_m with default parameters.
module tb_axis_m;

    logic        aclk;
    logic        areset_n;
    logic [31:0] data;
    logic        send;
    logic        full;
    logic [7:0]  pkt_len;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic [31:0] tdata;
    logic        finish;

    int errors;
    int checks;
    int fin_cnt;
    logic [31:0] cap_data[$];
    logic        cap_last[$];
    logic [31:0] exp_data[$];

    axis_m #(
        .DATA_WIDTH (32),
        .FIFO_DEPTH (4),
        .LEN_WIDTH  (8)
    ) u_dut (
        .aclk     (aclk),
        .areset_n (areset_n),
        .data     (data),
        .send     (send),
        .full     (full),
        .pkt_len  (pkt_len),
        .tvalid   (tvalid),
        .tready   (tready),
        .tlast    (tlast),
        .tdata    (tdata),
        .finish   (finish)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Record the handshake seen at the coming edge, then settle 1ns past it.
    task automatic step();
        if (tvalid && tready) begin
            cap_data.push_back(tdata);
            cap_last.push_back(tlast);
        end
        @(posedge aclk);
        #1;
        if (finish) fin_cnt++;
    endtask

    task automatic push(input logic [31:0] d);
        send = 1'b1;
        data = d;
        step();
    endtask

    task automatic do_reset();
        send     = 1'b0;
        tready   = 1'b0;
        areset_n = 1'b0;
        step();
        step();
        areset_n = 1'b1;
        cap_data.delete();
        cap_last.delete();
        exp_data.delete();
        fin_cnt = 0;
    endtask

    task automatic drain(input int n);
        int budget;
        budget = 40;
        send   = 1'b0;
        tready = 1'b1;
        while (cap_data.size() < n && budget > 0) begin
            step();
            budget--;
        end
        step();
        step();
        chk("drain_count", cap_data.size(), n);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        fin_cnt  = 0;
        areset_n = 1'b0;
        send     = 1'b0;
        data     = 32'h0;
        tready   = 1'b0;
        pkt_len  = 8'd3;
        #2;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_finish", finish, 1'b0);
        chk("rst_full", full, 1'b0);

        // 3-beat packet, no backpressure
        do_reset();
        pkt_len = 8'd3;
        tready  = 1'b1;
        push(32'hA1);
        chk("t1_no_bypass", tvalid, 1'b0);
        push(32'hA2);
        chk("t1_v1", tvalid, 1'b1);
        chk("t1_d1", tdata, 32'hA1);
        chk("t1_l1", tlast, 1'b0);
        push(32'hA3);
        chk("t1_d2", tdata, 32'hA2);
        chk("t1_l2", tlast, 1'b0);
        send = 1'b0;
        step();
        chk("t1_d3", tdata, 32'hA3);
        chk("t1_l3", tlast, 1'b1);
        chk("t1_fin_early", finish, 1'b0);
        step();
        chk("t1_fin", finish, 1'b1);
        chk("t1_v_drop", tvalid, 1'b0);
        step();
        chk("t1_fin_clear", finish, 1'b0);
        chk("t1_fin_cnt", fin_cnt, 1);
        chk("t1_ncap", cap_data.size(), 3);

        // Backpressure fill: output register + 4 entries, then drop
        do_reset();
        pkt_len = 8'd3;
        for (int i = 1; i <= 4; i++) push(32'hC0 + 32'(i));
        chk("t2_not_full", full, 1'b0);
        push(32'hC5);
        chk("t2_full", full, 1'b1);
        chk("t2_hold_v", tvalid, 1'b1);
        chk("t2_hold_d", tdata, 32'hC1);
        push(32'hC6);
        chk("t2_still_full", full, 1'b1);
        chk("t2_hold_d2", tdata, 32'hC1);
        drain(5);
        for (int k = 0; k < 5 && k < cap_data.size(); k++)
            chk($sformatf("t2_d%0d", k), cap_data[k], 32'hC1 + 32'(k));
        if (cap_last.size() >= 4) begin
            chk("t2_l3", cap_last[2], 1'b1);
            chk("t2_l4", cap_last[3], 1'b0);
        end
        chk("t2_fin_cnt", fin_cnt, 1);

        // pkt_len = 0 behaves as single-beat packets
        do_reset();
        pkt_len = 8'd0;
        push(32'hB1);
        push(32'hB2);
        drain(2);
        for (int k = 0; k < 2 && k < cap_last.size(); k++)
            chk($sformatf("t3_last%0d", k), cap_last[k], 1'b1);
        chk("t3_fin_cnt", fin_cnt, 2);

        // pkt_len change mid-packet only affects the next packet
        do_reset();
        pkt_len = 8'd4;
        tready  = 1'b1;
        push(32'hD1);
        push(32'hD2);
        pkt_len = 8'd2;
        for (int i = 3; i <= 6; i++) push(32'hD0 + 32'(i));
        drain(6);
        for (int k = 0; k < 6 && k < cap_last.size(); k++) begin
            chk($sformatf("t4_d%0d", k), cap_data[k], 32'hD1 + 32'(k));
            chk($sformatf("t4_l%0d", k), cap_last[k], (k == 3 || k == 5) ? 1'b1 : 1'b0);
        end
        chk("t4_fin_cnt", fin_cnt, 2);

        // Reset in the middle of a packet
        do_reset();
        pkt_len = 8'd4;
        tready  = 1'b1;
        for (int i = 1; i <= 4; i++) push(32'hE0 + 32'(i));
        chk("t5_two_hs", cap_data.size(), 2);
        send     = 1'b0;
        areset_n = 1'b0;
        #1;
        chk("t5_rst_v", tvalid, 1'b0);
        chk("t5_rst_d", tdata, 32'h0);
        chk("t5_rst_l", tlast, 1'b0);
        chk("t5_rst_full", full, 1'b0);
        step();
        areset_n = 1'b1;
        cap_data.delete();
        cap_last.delete();
        fin_cnt = 0;
        for (int i = 1; i <= 4; i++) push(32'hF0 + 32'(i));
        drain(4);
        for (int k = 0; k < 4 && k < cap_data.size(); k++) begin
            chk($sformatf("t5_d%0d", k), cap_data[k], 32'hF1 + 32'(k));
            chk($sformatf("t5_l%0d", k), cap_last[k], (k == 3) ? 1'b1 : 1'b0);
        end
        chk("t5_fin_cnt", fin_cnt, 1);

        // Toggling tready with continuous writes: order kept, none lost or doubled
        begin
            logic saw_full;
            saw_full = 1'b0;
            do_reset();
            pkt_len = 8'd3;
            for (int i = 0; i < 16; i++) begin
                tready = (i % 2 == 0) ? 1'b1 : 1'b0;
                if (full) saw_full = 1'b1;
                if (!full) exp_data.push_back(32'h100 + 32'(i));
                push(32'h100 + 32'(i));
            end
            drain(exp_data.size());
            chk("t6_saw_full", saw_full, 1'b1);
            for (int k = 0; k < exp_data.size() && k < cap_data.size(); k++) begin
                chk($sformatf("t6_d%0d", k), cap_data[k], exp_data[k]);
                chk($sformatf("t6_l%0d", k), cap_last[k], (k % 3 == 2) ? 1'b1 : 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
